// File: rtl/uart_pkg.sv
// Shared UART link definitions used by the receive-side and transmit-side word buffers.
package uart_pkg;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } uart_rx_state_t;

    localparam int BYTES_PER_WORD      = 4;
    localparam int UART_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter: counts enabled cycles, clears on demand, flags the last allowed cycle.
module uart_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry is only meaningful on a cycle where the count would otherwise advance.
    assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_buf_rx.sv
// Packs four received UART bytes (first byte in the LSBs) into a 32-bit word behind a valid/ready handshake.
module uart_buf_rx #(
    parameter int BYTES_PER_WORD = uart_pkg::BYTES_PER_WORD,
    parameter int TIMEOUT_CYCLES = uart_pkg::UART_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic [7:0]  rx_byte,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    import uart_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    uart_rx_state_t state;
    logic [1:0]     idx;
    logic [31:0]    shreg;
    logic           collecting;
    logic           expired;
    logic           to_clr;
    logic           to_en;

    assign collecting = (state == S_COLLECT);
    assign busy       = collecting;
    assign to_en      = collecting && !rx_done;
    assign to_clr     = rx_done || !collecting || expired;

    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (to_clr),
        .en     (to_en),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            shreg       <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (rx_done) begin
                        shreg[7:0] <= rx_byte;
                        idx        <= 2'd1;
                        state      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (rx_done) begin
                        shreg[{idx, 3'b000} +: 8] <= rx_byte;
                        if (idx == LAST_IDX) begin
                            state <= S_IDLE;
                            idx   <= '0;
                            // A word completing while the consumer takes the old one replaces it seamlessly.
                            if (!rvalid || rready) begin
                                rdata  <= {rx_byte, shreg[23:0]};
                                rvalid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else if (expired) begin
                        state       <= S_IDLE;
                        idx         <= '0;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_buf_rx.sv
// Directed bench for uart_buf_rx with a short inter-byte timeout.
module tb_uart_buf_rx;

    logic        clk;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rx_byte;
    logic        rready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    uart_buf_rx #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_byte    (rx_byte),
        .rready     (rready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_done = 1'b1;
        rx_byte = b;
        tick();
        rx_done = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic consume();
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        rready  = 1'b0;
        #1;
        check1("reset_rvalid", rvalid, 1'b0);
        check32("reset_rdata", rdata, 32'h0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_overrun", overrun, 1'b0);
        check1("reset_timeout", timeout_err, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Basic word, bytes 10 cycles apart
        strobe(8'h11);
        check1("t1_busy_after_b0", busy, 1'b1);
        idle(9);
        strobe(8'h22);
        idle(9);
        strobe(8'h33);
        check1("t1_rvalid_before_last", rvalid, 1'b0);
        idle(9);
        strobe(8'h44);
        check1("t1_rvalid", rvalid, 1'b1);
        check32("t1_rdata", rdata, 32'h44332211);
        check1("t1_busy", busy, 1'b0);
        check1("t1_overrun", overrun, 1'b0);
        check1("t1_timeout", timeout_err, 1'b0);

        // Second word while full: dropped with overrun
        strobe(8'hDD);
        strobe(8'hCC);
        strobe(8'hBB);
        strobe(8'hAA);
        check1("t2_overrun_pulse", overrun, 1'b1);
        check32("t2_rdata_kept", rdata, 32'h44332211);
        check1("t2_rvalid_kept", rvalid, 1'b1);
        tick();
        check1("t2_overrun_cleared", overrun, 1'b0);
        consume();
        check1("t2_rvalid_consumed", rvalid, 1'b0);
        tick();
        check1("t2_rready_idle_ignored", rvalid, 1'b0);

        // Completion coinciding with consumption
        strobe(8'h55);
        strobe(8'h66);
        strobe(8'h77);
        strobe(8'h88);
        check32("t3_pending_rdata", rdata, 32'h88776655);
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        rready = 1'b1;
        strobe(8'h04);
        rready = 1'b0;
        check1("t3_rvalid_stays", rvalid, 1'b1);
        check32("t3_rdata_new", rdata, 32'h04030201);
        check1("t3_no_overrun", overrun, 1'b0);
        consume();
        check1("t3_rvalid_consumed", rvalid, 1'b0);

        // Timeout after two bytes
        strobe(8'hE0);
        strobe(8'hE1);
        idle(15);
        check1("t4_no_timeout_early", timeout_err, 1'b0);
        check1("t4_busy_early", busy, 1'b1);
        tick();
        check1("t4_timeout_pulse", timeout_err, 1'b1);
        check1("t4_busy_cleared", busy, 1'b0);
        check1("t4_rvalid_unaffected", rvalid, 1'b0);
        tick();
        check1("t4_timeout_one_cycle", timeout_err, 1'b0);
        strobe(8'hA0);
        strobe(8'hA1);
        strobe(8'hA2);
        strobe(8'hA3);
        check1("t4_rvalid", rvalid, 1'b1);
        check32("t4_rdata", rdata, 32'hA3A2A1A0);
        consume();

        // Byte on the expiry cycle wins over the timeout
        strobe(8'h10);
        strobe(8'h20);
        idle(15);
        strobe(8'h30);
        check1("t5_no_timeout", timeout_err, 1'b0);
        check1("t5_busy", busy, 1'b1);
        idle(3);
        check1("t5_still_no_timeout", timeout_err, 1'b0);
        strobe(8'h40);
        check1("t5_rvalid", rvalid, 1'b1);
        check32("t5_rdata", rdata, 32'h40302010);
        consume();

        // Reset mid-word
        strobe(8'h77);
        strobe(8'h66);
        #2;
        rst_n = 1'b0;
        #1;
        check1("t6_busy_reset", busy, 1'b0);
        check1("t6_rvalid_reset", rvalid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        // Reset with a pending word
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        strobe(8'h04);
        check1("t6_pending", rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("t6_rvalid_async", rvalid, 1'b0);
        check32("t6_rdata_async", rdata, 32'h0);
        check1("t6_overrun_async", overrun, 1'b0);
        check1("t6_timeout_async", timeout_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        strobe(8'h9A);
        strobe(8'hBC);
        strobe(8'hDE);
        strobe(8'hF0);
        check1("t6_fresh_rvalid", rvalid, 1'b1);
        check32("t6_fresh_rdata", rdata, 32'hF0DEBC9A);
        check1("t6_fresh_overrun", overrun, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_buf_rx.md
Name: uart_buf_rx

Overview:
- Receive-side word assembler for the game's UART link.
- Collects four consecutive bytes from the UART receiver and packs them into one 32-bit word for game logic (remote paddle/score/state exchange).
- Presents the word with a valid/ready handshake.
- Inter-byte timeout resynchronises framing after line glitches or a partial word.

Parameters:
- BYTES_PER_WORD, 4, bytes per assembled word; fixed at 4 for the 32-bit output.
- TIMEOUT_CYCLES, 200000, max clk cycles allowed between bytes of one word before the partial word is discarded.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter. Derived; do not override.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- rx_done, input, 1, single-cycle strobe from the UART receiver: rx_byte is valid.
- rx_byte, input, 8, received byte; sampled only when rx_done=1.
- rready, input, 1, consumer accepts rdata this cycle when rvalid=1.
- rdata, output, 32, assembled word; stable while rvalid=1.
- rvalid, output, 1, rdata holds an unconsumed word.
- busy, output, 1, a partial word is being collected (1..3 bytes held).
- overrun, output, 1, one-cycle pulse: a completed word was dropped because the output was still full.
- timeout_err, output, 1, one-cycle pulse: a partial word was discarded on timeout.

Behaviour:
- Reset (async assert, sync release): all outputs and internal state are 0. State S_IDLE, byte index 0, timeout counter 0, shift register 0.
- Byte order: first byte received goes to rdata[7:0], second to [15:8], third to [23:16], fourth to [31:24].
- State S_IDLE:
  - rx_done=1: store byte 0, idx=1, counter=0, go to S_COLLECT.
  - busy=0 in this state.
- State S_COLLECT (busy=1):
  - Counter increments every cycle rx_done=0.
  - rx_done=1: store byte at idx and reset counter.
  - If idx=3 when rx_done=1, the word is complete: go to S_IDLE, idx=0.
  - Otherwise idx increments.
- Timeout: in S_COLLECT with rx_done=0 and counter = TIMEOUT_CYCLES-1:
  - Discard the partial word and pulse timeout_err for 1 cycle.
  - Go to S_IDLE with idx=0 and counter=0.
  - rvalid/rdata are unaffected.
- Timeout vs byte: rx_done=1 on the expiry cycle wins. The byte is accepted, the counter resets, and no timeout_err is raised.
- Completion latency: rvalid=1 and rdata loaded on the clock edge that samples the 4th rx_done, i.e. visible the cycle after the strobe.
- Output handshake: the word transfers on a cycle with rvalid=1 and rready=1. rvalid drops on the next edge unless a new word completes on that same cycle.
- Completion while full:
  - rvalid=1, rready=0: new word is dropped, rdata keeps the old word, overrun pulses 1 cycle.
  - rvalid=1, rready=1 on the same cycle: old word is consumed, new word loaded, rvalid stays 1, no overrun.
- rready while rvalid=0 is ignored.
- rx_done is never required high for more than 1 cycle. Each high cycle counts as a separate byte.
- Reset mid-word or with rvalid=1: everything cleared immediately. The partial or pending word is lost with no error pulse.

Decomposition:
- Shared package uart_pkg:
  - state enum typedef {S_IDLE, S_COLLECT} as uart_rx_state_t.
  - localparam BYTES_PER_WORD=4.
  - Default TIMEOUT_CYCLES constant, shared with the transmit-side buffer.
- Sub-module uart_rx_timeout:
  - Loadable counter with clear, enable and an `expired` output, parameterised by TIMEOUT_CYCLES.
  - Instantiated once.
- Byte packing, state register and output register stay in the top.

Test Plan:
- Four strobes, bytes 0x11,0x22,0x33,0x44, each 10 cycles apart, rready=0 → rvalid=1 one cycle after the 4th strobe, rdata=0x44332211, busy=0, no error pulses.
- Word pending (rready=0), then a second word 0xDD,0xCC,0xBB,0xAA → overrun pulses 1 cycle after the last strobe, rdata stays 0x44332211. Then rready=1 for 1 cycle → rvalid=0 next cycle.
- Pending word, 4th strobe of 0x01,0x02,0x03,0x04 coincides with rready=1 → rvalid stays 1, rdata=0x04030201, overrun=0.
- TIMEOUT_CYCLES=16; send 2 bytes then idle → timeout_err pulses exactly 16 cycles after the 2nd strobe, busy=0. Next 4 bytes 0xA0..0xA3 → rdata=0xA3A2A1A0.
- TIMEOUT_CYCLES=16; 3rd strobe lands on the expiry cycle → no timeout_err, busy=1. 4th byte completes the word correctly.
- rst_n asserted after 2 bytes and again while rvalid=1 → all outputs 0 asynchronously. After release, a fresh 4-byte word assembles correctly.
